// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for unsigned or two's-complement
// operands. It produces one quotient bit per clock, most significant bit first.
//
// Ports:
//   i_clock      sole clock; all state changes on its rising edge
//   i_reset      asynchronous, active-low reset
//   i_start      start request, sampled only in IDLE
//   i_abort      cancel the operation in progress (no effect in IDLE)
//   i_signed     1 = two's-complement operands, 0 = unsigned (latched on start)
//   i_dividend   dividend (latched on start)
//   i_divisor    divisor (latched on start)
//   o_busy       high in every state except IDLE
//   o_finished   one-cycle completion pulse (DONE state)
//   o_quotient   quotient, held from one DONE to the next
//   o_remainder  remainder, held from one DONE to the next
//   o_undefined  divisor was zero
//   o_overflow   signed quotient not representable (-2^(N-1) / -1)
module seq_divider #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic         i_signed,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_finished,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_undefined,
  output logic         o_overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ITERATE = 3'd2,
    FIXUP   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;          // raw latched dividend
  logic [N-1:0]   b_q, b_d;          // raw latched divisor
  logic           sgn_q, sgn_d;      // signed mode
  logic [N-1:0]   dvd_q, dvd_d;      // dividend magnitude, shifts into quotient
  logic [N-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic [N-1:0]   rem_q, rem_d;      // partial remainder
  logic [CW-1:0]  cnt_q, cnt_d;      // iterations remaining minus one
  logic           negq_q, negq_d;    // quotient must be negated
  logic           negr_q, negr_d;    // remainder must be negated
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rmd_q, rmd_d;
  logic           undef_q, undef_d;
  logic           ovf_q, ovf_d;

  // Trial subtraction: the partial remainder shifted left with the next dividend bit appended.
  logic [N:0]     shifted_s;
  logic [N:0]     trial_s;
  logic           fits_s;

  function automatic logic [N-1:0] neg_f(input logic [N-1:0] x);
    return {N{1'b0}} - x;
  endfunction

  // Restoring step: subtract the divisor when it fits, otherwise keep the shifted value.
  always_comb begin
    shifted_s = {rem_q, dvd_q[N-1]};
    trial_s   = shifted_s - {1'b0, dvs_q};
    fits_s    = (shifted_s >= {1'b0, dvs_q});
  end

  // Next-state and datapath updates; abort wins in every non-IDLE state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    undef_d = undef_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_dividend;
          b_d     = i_divisor;
          sgn_d   = i_signed;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (b_q == {N{1'b0}}) begin
          quo_d   = {N{1'b1}};
          rmd_d   = a_q;
          undef_d = 1'b1;
          ovf_d   = 1'b0;
          state_d = DONE;
        end else begin
          dvd_d   = (sgn_q && a_q[N-1]) ? neg_f(a_q) : a_q;
          dvs_d   = (sgn_q && b_q[N-1]) ? neg_f(b_q) : b_q;
          negq_d  = sgn_q & (a_q[N-1] ^ b_q[N-1]);
          negr_d  = sgn_q & a_q[N-1];
          rem_d   = {N{1'b0}};
          cnt_d   = CW'(N - 1);
          state_d = ITERATE;
        end
      end
      ITERATE: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          rem_d = fits_s ? trial_s[N-1:0] : shifted_s[N-1:0];
          dvd_d = {dvd_q[N-2:0], fits_s};
          if (cnt_q == {CW{1'b0}}) begin
            state_d = FIXUP;
          end else begin
            cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            state_d = ITERATE;
          end
        end
      end
      FIXUP: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          quo_d   = negq_q ? neg_f(dvd_q) : dvd_q;
          rmd_d   = negr_q ? neg_f(rem_q) : rem_q;
          undef_d = 1'b0;
          // Only -2^(N-1) / -1 yields a positive magnitude with the top bit set.
          ovf_d   = sgn_q & ~negq_q & dvd_q[N-1];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      sgn_q   <= 1'b0;
      dvd_q   <= {N{1'b0}};
      dvs_q   <= {N{1'b0}};
      rem_q   <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= {N{1'b0}};
      rmd_q   <= {N{1'b0}};
      undef_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      undef_q <= undef_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_finished  = (state_q == DONE);
  assign o_quotient  = quo_q;
  assign o_remainder = rmd_q;
  assign o_undefined = undef_q;
  assign o_overflow  = ovf_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port i_clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_start  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port i_abort  input  1  cancel the operation in progress.
REQ-006 SHALL have port i_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with i_start.
REQ-007 SHALL have port i_dividend  input  N  dividend; latched with i_start.
REQ-008 SHALL have port i_divisor  input  N  divisor; latched with i_start.
REQ-009 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port o_finished  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_quotient  output  N  quotient.
REQ-012 SHALL have port o_remainder  output  N  remainder.
REQ-013 SHALL have port o_undefined  output  1  divisor was zero.
REQ-014 SHALL have port o_overflow  output  1  signed quotient not representable.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ITERATE, FIXUP, DONE; subtractor internal, no external datapath ports.
REQ-016 IDLE: i_start=1 at an edge SHALL latch i_signed/i_dividend/i_divisor and go to SETUP.
REQ-017 SETUP (1 cycle): SHALL take magnitudes of operands when i_signed=1, record result signs, clear partial remainder, load iteration counter N-1, go to ITERATE; divisor zero SHALL go directly to DONE.
REQ-018 ITERATE: SHALL do restoring division, one quotient bit per cycle MSB first, using an (N+1)-bit trial subtraction; exactly N cycles, then FIXUP.
REQ-019 FIXUP (1 cycle): SHALL negate quotient if operand signs differ and negate remainder if dividend negative (signed mode only), then go to DONE.
REQ-020 DONE (1 cycle): o_finished SHALL be 1 and outputs SHALL update this cycle; next state IDLE.
REQ-021 Normal latency: o_finished SHALL be high in the cycle after the (N+3)th rising edge counted from the edge that sampled i_start (inclusive); divide-by-zero: after the 2nd edge.
REQ-022 Signed results SHALL truncate toward zero; remainder sign SHALL equal dividend sign; |remainder| < |divisor|.
REQ-023 Divisor zero: o_quotient SHALL be all-ones, o_remainder = dividend, o_undefined=1, o_overflow=0.
REQ-024 Signed -2^(N-1) / -1: o_quotient SHALL be -2^(N-1), o_remainder 0, o_overflow=1.
REQ-025 o_quotient, o_remainder, o_undefined, o_overflow SHALL hold their values from the last DONE until the next DONE.
REQ-026 i_start while o_busy=1 SHALL be ignored; i_start high in the DONE cycle SHALL be ignored.
REQ-027 i_abort=1 at an edge in any non-IDLE state SHALL force IDLE next cycle, no o_finished, outputs unchanged; i_abort has priority over i_start; i_abort in IDLE has no effect.
REQ-028 Input changes after the latching edge SHALL not affect the result.

Reset
REQ-029 i_reset=0 SHALL immediately force IDLE, o_busy=0, o_finished=0, o_quotient=0, o_remainder=0, o_undefined=0, o_overflow=0, independent of i_clock.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no o_finished after release.
REQ-031 First i_start SHALL be sampled at the first rising edge with i_reset=1.

Verification
REQ-032 N=8, unsigned 200/7 -> quotient 28, remainder 4, o_finished high one cycle, 11 edges after start edge.
REQ-033 N=8, signed -7/2 -> quotient 0xFD (-3), remainder 0xFF (-1); signed 7/-2 -> quotient -3, remainder 1.
REQ-034 N=8, 55/0 -> quotient 0xFF, remainder 55, o_undefined=1, o_finished 2 edges after start edge.
REQ-035 N=8, signed 0x80/0xFF -> quotient 0x80, remainder 0, o_overflow=1; same operands unsigned -> quotient 0, remainder 0x80, o_overflow=0.
REQ-036 Start 100/3, pulse i_abort at 4th ITERATE cycle -> IDLE next cycle, no o_finished, outputs retain prior values; new start 9/4 -> quotient 2, remainder 1.
REQ-037 Randomised N=4 and N=16, both modes, against reference model including i_reset=0 mid-ITERATE -> all outputs zero immediately, no pulse.
